// File: rtl/usb_tx_pktgen.sv
// usb_tx_pktgen: device-side USB packet formatter.
// Streams SYNC, PID, optional payload and CRC16 bytewise to the line driver,
// then waits for the line driver to finish EOP before reporting completion.

module usb_tx_pktgen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txpkt_start,
  output logic       txpkt_done,
  input  logic [3:0] txpkt_pid,
  input  logic [9:0] txpkt_len,
  input  logic [7:0] txpkt_data,
  output logic       txpkt_data_ack,
  output logic [7:0] ll_data,
  output logic       ll_valid,
  output logic       ll_last,
  input  logic       ll_ready,
  input  logic       ll_done
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC_LO,
    CRC_HI,
    WAIT_EOP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  pid_r;
  logic [9:0]  cnt;
  logic [15:0] crc;
  logic        is_data_pid;

  // Data PIDs (DATA0/DATA1/DATA2/MDATA) all end in binary 11.
  assign is_data_pid = (pid_r[1:0] == 2'b11);

  // One byte of the USB CRC16: LSB-first, reflected polynomial 0xA001.
  function automatic logic [15:0] crc16_fold(input logic [15:0] c_in,
                                             input logic [7:0]  d_in);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d_in[i]) begin
        c = (c >> 1) ^ 16'hA001;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and line-side outputs; outputs only depend on state and
  // latched packet info, never on ll_ready, except the payload ack.
  always_comb begin
    state_nxt      = state;
    ll_valid       = 1'b0;
    ll_data        = 8'h00;
    ll_last        = 1'b0;
    txpkt_data_ack = 1'b0;
    case (state)
      IDLE: begin
        if (txpkt_start) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        ll_valid = 1'b1;
        ll_data  = 8'h80;
        if (ll_ready) begin
          state_nxt = PID;
        end
      end
      PID: begin
        ll_valid = 1'b1;
        ll_data  = {~pid_r, pid_r};
        ll_last  = ~is_data_pid;
        if (ll_ready) begin
          if (!is_data_pid) begin
            state_nxt = WAIT_EOP;
          end else if (cnt != 10'd0) begin
            state_nxt = DATA;
          end else begin
            state_nxt = CRC_LO;
          end
        end
      end
      DATA: begin
        ll_valid       = 1'b1;
        ll_data        = txpkt_data;
        txpkt_data_ack = ll_ready;
        if (ll_ready && (cnt == 10'd1)) begin
          state_nxt = CRC_LO;
        end
      end
      CRC_LO: begin
        ll_valid = 1'b1;
        ll_data  = ~crc[7:0];
        if (ll_ready) begin
          state_nxt = CRC_HI;
        end
      end
      CRC_HI: begin
        ll_valid = 1'b1;
        ll_data  = ~crc[15:8];
        ll_last  = 1'b1;
        if (ll_ready) begin
          state_nxt = WAIT_EOP;
        end
      end
      WAIT_EOP: begin
        if (ll_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Packet context: latch PID/length on start, fold each accepted payload
  // byte into the CRC and count it down; register the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_r      <= 4'h0;
      cnt        <= 10'd0;
      crc        <= 16'hFFFF;
      txpkt_done <= 1'b0;
    end else begin
      txpkt_done <= (state == WAIT_EOP) && ll_done;
      if ((state == IDLE) && txpkt_start) begin
        pid_r <= txpkt_pid;
        cnt   <= txpkt_len;
        crc   <= 16'hFFFF;
      end else if ((state == DATA) && ll_ready) begin
        crc <= crc16_fold(crc, txpkt_data);
        cnt <= cnt - 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_pktgen.sv
// tb_usb_tx_pktgen: self-checking bench for usb_tx_pktgen.
// A byte-queue model of the expected packet is compared every cycle, and a
// few literal streams pin the model to known USB packets.

module tb_usb_tx_pktgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txpkt_start = 1'b0;
  logic       txpkt_done;
  logic [3:0] txpkt_pid = 4'h0;
  logic [9:0] txpkt_len = 10'd0;
  logic [7:0] txpkt_data;
  logic       txpkt_data_ack;
  logic [7:0] ll_data;
  logic       ll_valid;
  logic       ll_last;
  logic       ll_ready = 1'b1;
  logic       ll_done = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  usb_tx_pktgen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .txpkt_start    (txpkt_start),
    .txpkt_done     (txpkt_done),
    .txpkt_pid      (txpkt_pid),
    .txpkt_len      (txpkt_len),
    .txpkt_data     (txpkt_data),
    .txpkt_data_ack (txpkt_data_ack),
    .ll_data        (ll_data),
    .ll_valid       (ll_valid),
    .ll_last        (ll_last),
    .ll_ready       (ll_ready),
    .ll_done        (ll_done)
  );

  // Payload buffer: read pointer rewinds with a real start and advances per ack.
  logic [7:0] mem [0:1023];
  logic [9:0] ptr = 10'd0;
  logic       rewind = 1'b0;
  assign txpkt_data = mem[ptr];

  always @(posedge clk) begin
    if (rewind) ptr <= 10'd0;
    else if (txpkt_data_ack) ptr <= ptr + 10'd1;
  end

  // Line driver readiness: constant or random per cycle.
  bit ready_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    ll_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of the bytes the packet must contain.
  typedef struct packed {
    logic       pay;
    logic       last;
    logic [7:0] data;
  } ent_t;

  ent_t m_q[$];
  bit   m_in_eop = 1'b0;
  bit   m_done_pend = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;

  logic [7:0] acc_data[$];
  logic       acc_last[$];
  int         ack_cyc[$];
  int         done_rel = -1;
  logic [7:0] exp_bytes[$];

  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ mem[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic void push_ent(input logic p, input logic l, input logic [7:0] d);
    ent_t e;
    e.pay  = p;
    e.last = l;
    e.data = d;
    m_q.push_back(e);
  endfunction

  function automatic void model_load(input logic [3:0] pid, input int len);
    logic [15:0] c;
    bit dp;
    dp = (pid[1:0] == 2'b11);
    m_q.delete();
    push_ent(1'b0, 1'b0, 8'h80);
    push_ent(1'b0, !dp, {~pid, pid});
    if (dp) begin
      for (int i = 0; i < len; i++) push_ent(1'b1, 1'b0, mem[i]);
      c = model_crc(len);
      push_ent(1'b0, 1'b0, ~c[7:0]);
      push_ent(1'b0, 1'b1, ~c[15:8]);
    end
  endfunction

  // Compare process: check every output mid-cycle, then advance the model.
  bit exp_valid, idle_now, popped_last;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      checkOutput("reset_outputs", {txpkt_done, txpkt_data_ack, ll_valid, ll_last, ll_data}, 32'h0);
      m_q.delete();
      m_in_eop    = 1'b0;
      m_done_pend = 1'b0;
    end else begin
      exp_valid = (m_q.size() > 0);
      checkOutput("ll_valid", ll_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("ll_data", ll_data, m_q[0].data);
        checkOutput("ll_last", ll_last, m_q[0].last);
        checkOutput("data_ack", txpkt_data_ack, ll_ready & m_q[0].pay);
      end else begin
        checkOutput("data_ack_idle", txpkt_data_ack, 1'b0);
      end
      checkOutput("txpkt_done", txpkt_done, m_done_pend);

      if (ll_valid && ll_ready) begin
        acc_data.push_back(ll_data);
        acc_last.push_back(ll_last);
      end
      if (txpkt_data_ack) ack_cyc.push_back(cyc - start_cyc);
      if (txpkt_done) done_rel = cyc - start_cyc;

      idle_now    = (m_q.size() == 0) && !m_in_eop;
      m_done_pend = 1'b0;
      if (m_in_eop && ll_done) begin
        m_done_pend = 1'b1;
        m_in_eop    = 1'b0;
      end
      if (exp_valid && ll_ready) begin
        popped_last = m_q[0].last;
        void'(m_q.pop_front());
        if (popped_last) m_in_eop = 1'b1;
      end
      if (idle_now && txpkt_start) begin
        model_load(txpkt_pid, int'(txpkt_len));
        start_cyc = cyc;
      end
    end
  end

  // One packet: start, optional start re-pulse, wait for EOP, send ll_done.
  task automatic applyStimulus(input logic [3:0] pid, input int len, input bit rnd,
                               input int done_delay, input bit repulse);
    acc_data.delete();
    acc_last.delete();
    ack_cyc.delete();
    done_rel   = -1;
    ready_rand = rnd;
    @(posedge clk); #2;
    txpkt_start = 1'b1;
    txpkt_pid   = pid;
    txpkt_len   = 10'(len);
    rewind      = 1'b1;
    @(posedge clk); #2;
    txpkt_start = 1'b0;
    rewind      = 1'b0;
    txpkt_pid   = 4'($urandom);
    txpkt_len   = 10'($urandom);
    for (int i = 0; i < 3000 && !m_in_eop; i++) begin
      txpkt_start = (repulse && i == 4);
      ll_done     = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #2;
    end
    txpkt_start = 1'b0;
    ll_done     = 1'b0;
    checkOutput("eop_reached", m_in_eop, 1'b1);
    for (int i = 0; i < done_delay; i++) begin
      @(posedge clk); #2;
    end
    ll_done = 1'b1;
    @(posedge clk); #2;
    ll_done = 1'b0;
    @(posedge clk); #2;
    checkOutput("done_seen", (done_rel >= 0), 1'b1);
    ready_rand = 1'b0;
  endtask

  // Compare the accepted stream with exp_bytes, including the single ll_last.
  task automatic checkStream(input string name);
    int nlast;
    int lastpos;
    checkOutput({name, "_len"}, acc_data.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      checkOutput(name, (i < acc_data.size()) ? {24'h0, acc_data[i]} : 32'hDEAD, exp_bytes[i]);
    end
    nlast   = 0;
    lastpos = -1;
    for (int i = 0; i < acc_last.size(); i++) begin
      if (acc_last[i]) begin
        nlast++;
        lastpos = i;
      end
    end
    checkOutput({name, "_nlast"}, nlast, 1);
    checkOutput({name, "_lastpos"}, lastpos, exp_bytes.size() - 1);
  endtask

  // Reset in the middle of a DATA phase, then show no completion follows.
  task automatic abortTest();
    acc_data.delete();
    acc_last.delete();
    ack_cyc.delete();
    done_rel   = -1;
    ready_rand = 1'b0;
    @(posedge clk); #2;
    txpkt_start = 1'b1;
    txpkt_pid   = 4'h3;
    txpkt_len   = 10'd20;
    rewind      = 1'b1;
    @(posedge clk); #2;
    txpkt_start = 1'b0;
    rewind      = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checkOutput("abort_in_data", txpkt_data_ack, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs_zero", {txpkt_done, txpkt_data_ack, ll_valid, ll_last, ll_data}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #2;
    ll_done = 1'b1;
    @(posedge clk); #2;
    ll_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("no_done_after_abort", done_rel, -1);
  endtask

  // Main sequence.
  initial begin
    logic [3:0] rpid;
    int rlen;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {txpkt_done, txpkt_data_ack, ll_valid, ll_last, ll_data}, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    checkOutput("model_crc_123456789", model_crc(9), 16'h4B37);

    $display("[TB] ACK handshake");
    applyStimulus(4'h2, 0, 1'b0, 2, 1'b0);
    exp_bytes = '{8'h80, 8'hD2};
    checkStream("ack_stream");
    checkOutput("ack_no_acks", ack_cyc.size(), 0);
    checkOutput("ack_done_cycle", done_rel, 6);

    $display("[TB] DATA0 123456789");
    applyStimulus(4'h3, 9, 1'b0, 3, 1'b0);
    exp_bytes = '{8'h80, 8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'hC8, 8'hB4};
    checkStream("data0_stream");
    checkOutput("data0_ack_count", ack_cyc.size(), 9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("data0_ack_cycle", (i < ack_cyc.size()) ? ack_cyc[i] : -1, 3 + i);
    end

    $display("[TB] DATA1 zero length");
    applyStimulus(4'hB, 0, 1'b0, 1, 1'b0);
    exp_bytes = '{8'h80, 8'h4B, 8'h00, 8'h00};
    checkStream("zlp_stream");
    checkOutput("zlp_ack_count", ack_cyc.size(), 0);

    $display("[TB] Backpressure");
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    applyStimulus(4'h3, 4, 1'b0, 1, 1'b0);
    exp_bytes = acc_data;
    applyStimulus(4'h3, 4, 1'b1, 2, 1'b0);
    checkStream("bp_stream");
    checkOutput("bp_ack_count", ack_cyc.size(), 4);

    $display("[TB] Random packets");
    for (int k = 0; k < 10; k++) begin
      rpid = 4'($urandom);
      rlen = $urandom_range(0, 40);
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      applyStimulus(rpid, rlen, 1'b1, $urandom_range(0, 4), 1'b0);
      checkOutput("rand_ack_count", ack_cyc.size(), (rpid[1:0] == 2'b11) ? rlen : 0);
    end

    $display("[TB] Start re-pulse during DATA");
    for (int i = 0; i < 12; i++) mem[i] = 8'($urandom);
    applyStimulus(4'h3, 12, 1'b0, 1, 1'b1);
    checkOutput("repulse_len", acc_data.size(), 16);
    checkOutput("repulse_ack_count", ack_cyc.size(), 12);

    $display("[TB] Reset abort");
    abortTest();
    applyStimulus(4'h2, 0, 1'b0, 2, 1'b0);
    exp_bytes = '{8'h80, 8'hD2};
    checkStream("post_abort_ack");
    checkOutput("post_abort_done_cycle", done_rel, 6);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
